wb_bridge_nway: RTL and testbench

WB_BRIDGE_NWAY -- requirements
Module: wb_bridge_nway

---
 rtl/wb_bridge_pkg.sv | 15 +
 rtl/wb_bridge_nway_if.sv | 47 ++++
 rtl/wb_addr_decoder.sv | 31 +++
 rtl/wb_bridge_nway.sv | 189 ++++++++++++++++++
 tb/tb_wb_bridge_nway.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the N-way Wishbone bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          MAX_PORTS        = 8;
  localparam int          PORT_IDX_W       = $clog2(MAX_PORTS);
  localparam int          TMO_CNT_W        = 16;

endpackage

// File: rtl/wb_bridge_nway_if.sv
// Bundle of the bridge's upstream, downstream and status signals.
interface wb_bridge_nway_if #(
  parameter int N_PORTS        = 4,
  parameter int SUB_ADDR_WIDTH = 11
) ();

  logic                        wbs_stb_i;
  logic                        wbs_cyc_i;
  logic                        wbs_we_i;
  logic [3:0]                  wbs_sel_i;
  logic [31:0]                 wbs_dat_i;
  logic [31:0]                 wbs_adr_i;
  logic                        wbs_ack_o;
  logic [31:0]                 wbs_dat_o;

  logic [N_PORTS-1:0]          wbm_stb_o;
  logic [N_PORTS-1:0]          wbm_cyc_o;
  logic [N_PORTS-1:0]          wbm_ack_i;
  logic [N_PORTS*32-1:0]       wbm_dat_i;
  logic                        wbm_we_o;
  logic [3:0]                  wbm_sel_o;
  logic [31:0]                 wbm_dat_o;
  logic [SUB_ADDR_WIDTH-1:0]   wbm_adr_o;

  logic                        timeout_o;
  logic                        unmapped_o;
  logic [2:0]                  err_port_o;

  // Bridge-side view.
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o,
    input  wbm_ack_i, wbm_dat_i,
    output timeout_o, unmapped_o, err_port_o
  );

  // Upstream host / downstream device view.
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o,
    output wbm_ack_i, wbm_dat_i,
    input  timeout_o, unmapped_o, err_port_o
  );

endinterface

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching port wins.
module wb_addr_decoder
  import wb_bridge_pkg::*;
#(
  parameter int                    N_PORTS        = 4,
  parameter int                    SUB_ADDR_WIDTH = 11,
  parameter logic [N_PORTS*32-1:0] BASE_ADDR      = {32'h3000_3000, 32'h3000_2000,
                                                     32'h3000_1000, 32'h3000_0000},
  parameter logic [N_PORTS*32-1:0] ADDR_MASK      = {4{32'hFFFF_F000}}
) (
  input  logic [31:0]               adr_i,
  output logic                      hit_o,
  output logic [PORT_IDX_W-1:0]     port_o,
  output logic [SUB_ADDR_WIDTH-1:0] offset_o
);

  // Scan from the top so a lower-numbered match overwrites a higher one.
  always_comb begin
    hit_o    = 1'b0;
    port_o   = '0;
    offset_o = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if ((adr_i & ADDR_MASK[k*32 +: 32]) == (BASE_ADDR[k*32 +: 32] & ADDR_MASK[k*32 +: 32])) begin
        hit_o    = 1'b1;
        port_o   = PORT_IDX_W'(k);
        offset_o = SUB_ADDR_WIDTH'(adr_i & ~ADDR_MASK[k*32 +: 32]);
      end
    end
  end

endmodule

// File: rtl/wb_bridge_nway.sv
// One-to-N Wishbone bridge with address decode, ack timeout and error responses.
//   state | meaning
//   IDLE  | waiting for an upstream strobe
//   REQ   | downstream cyc/stb held on the selected port
//   RESP  | single-cycle upstream ack
module wb_bridge_nway
  import wb_bridge_pkg::*;
#(
  parameter int                    N_PORTS        = 4,
  parameter int                    SUB_ADDR_WIDTH = 11,
  parameter logic [N_PORTS*32-1:0] BASE_ADDR      = {32'h3000_3000, 32'h3000_2000,
                                                     32'h3000_1000, 32'h3000_0000},
  parameter logic [N_PORTS*32-1:0] ADDR_MASK      = {4{32'hFFFF_F000}},
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [N_PORTS-1:0]        wbm_stb_o,
  output logic [N_PORTS-1:0]        wbm_cyc_o,
  input  logic [N_PORTS-1:0]        wbm_ack_i,
  input  logic [N_PORTS*32-1:0]     wbm_dat_i,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [31:0]               wbm_dat_o,
  output logic [SUB_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                      timeout_o,
  output logic                      unmapped_o,
  output logic [2:0]                err_port_o
);

  localparam logic [TMO_CNT_W-1:0] TMO_LOAD = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic                      dec_hit;
  logic [PORT_IDX_W-1:0]     dec_port;
  logic [SUB_ADDR_WIDTH-1:0] dec_offset;

  wb_addr_decoder #(
    .N_PORTS       (N_PORTS),
    .SUB_ADDR_WIDTH(SUB_ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .ADDR_MASK     (ADDR_MASK)
  ) u_dec (
    .adr_i   (wbs_adr_i),
    .hit_o   (dec_hit),
    .port_o  (dec_port),
    .offset_o(dec_offset)
  );

  state_e                    state_q, state_d;
  logic [N_PORTS-1:0]        wbm_cyc_q, wbm_cyc_d;
  logic                      wbm_we_q, wbm_we_d;
  logic [3:0]                wbm_sel_q, wbm_sel_d;
  logic [31:0]               wbm_dat_q, wbm_dat_d;
  logic [SUB_ADDR_WIDTH-1:0] wbm_adr_q, wbm_adr_d;
  logic [PORT_IDX_W-1:0]     port_q, port_d;
  logic                      ack_q, ack_d;
  logic [31:0]               rdat_q, rdat_d;
  logic [TMO_CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      unmapped_q, unmapped_d;
  logic [PORT_IDX_W-1:0]     err_port_q, err_port_d;

  // The one-hot cyc register doubles as the port select, so acks from other ports mask out.
  logic        sel_ack;
  logic [31:0] sel_rdat;

  always_comb begin
    sel_ack  = |(wbm_ack_i & wbm_cyc_q);
    sel_rdat = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (wbm_cyc_q[k]) sel_rdat = wbm_dat_i[k*32 +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    wbm_cyc_d  = wbm_cyc_q;
    wbm_we_d   = wbm_we_q;
    wbm_sel_d  = wbm_sel_q;
    wbm_dat_d  = wbm_dat_q;
    wbm_adr_d  = wbm_adr_q;
    port_d     = port_q;
    ack_d      = 1'b0;
    rdat_d     = rdat_q;
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
    unmapped_d = unmapped_q;
    err_port_d = err_port_q;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (dec_hit) begin
            port_d    = dec_port;
            wbm_cyc_d = N_PORTS'(1) << dec_port;
            wbm_we_d  = wbs_we_i;
            wbm_sel_d = wbs_sel_i;
            wbm_dat_d = wbs_dat_i;
            wbm_adr_d = dec_offset;
            tmo_cnt_d = TMO_LOAD;
            state_d   = REQ;
          end else begin
            unmapped_d = 1'b1;
            rdat_d     = ERR_DATA;
            ack_d      = 1'b1;
            state_d    = RESP;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          wbm_cyc_d = '0;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else if (sel_ack) begin
          wbm_cyc_d = '0;
          tmo_cnt_d = '0;
          if (!wbm_we_q) rdat_d = sel_rdat;
          ack_d     = 1'b1;
          state_d   = RESP;
        end else if (tmo_cnt_q == '0) begin
          wbm_cyc_d  = '0;
          timeout_d  = 1'b1;
          err_port_d = port_q;
          rdat_d     = ERR_DATA;
          ack_d      = 1'b1;
          state_d    = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      wbm_cyc_q  <= '0;
      wbm_we_q   <= 1'b0;
      wbm_sel_q  <= '0;
      wbm_dat_q  <= '0;
      wbm_adr_q  <= '0;
      port_q     <= '0;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      unmapped_q <= 1'b0;
      err_port_q <= '0;
    end else begin
      state_q    <= state_d;
      wbm_cyc_q  <= wbm_cyc_d;
      wbm_we_q   <= wbm_we_d;
      wbm_sel_q  <= wbm_sel_d;
      wbm_dat_q  <= wbm_dat_d;
      wbm_adr_q  <= wbm_adr_d;
      port_q     <= port_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
      unmapped_q <= unmapped_d;
      err_port_q <= err_port_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = rdat_q;
  assign wbm_cyc_o  = wbm_cyc_q;
  assign wbm_stb_o  = wbm_cyc_q;
  assign wbm_we_o   = wbm_we_q;
  assign wbm_sel_o  = wbm_sel_q;
  assign wbm_dat_o  = wbm_dat_q;
  assign wbm_adr_o  = wbm_adr_q;
  assign timeout_o  = timeout_q;
  assign unmapped_o = unmapped_q;
  assign err_port_o = 3'(err_port_q);

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Self-checking bench for wb_bridge_nway: directed scenarios plus randomized traffic vs a transaction model.
module tb_wb_bridge_nway;

  localparam int          NP   = 4;
  localparam int          SAW  = 12;
  localparam int          T    = 16;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam logic [31:0] MASK = 32'hFFFF_F000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_bridge_nway_if #(.N_PORTS(NP), .SUB_ADDR_WIDTH(SAW)) bus ();

  wb_bridge_nway #(
    .N_PORTS       (NP),
    .SUB_ADDR_WIDTH(SAW),
    .BASE_ADDR     ({32'h3000_3000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000}),
    .ADDR_MASK     ({4{32'hFFFF_F000}}),
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (ERR)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (bus.wbs_stb_i),
    .wbs_cyc_i (bus.wbs_cyc_i),
    .wbs_we_i  (bus.wbs_we_i),
    .wbs_sel_i (bus.wbs_sel_i),
    .wbs_dat_i (bus.wbs_dat_i),
    .wbs_adr_i (bus.wbs_adr_i),
    .wbs_ack_o (bus.wbs_ack_o),
    .wbs_dat_o (bus.wbs_dat_o),
    .wbm_stb_o (bus.wbm_stb_o),
    .wbm_cyc_o (bus.wbm_cyc_o),
    .wbm_ack_i (bus.wbm_ack_i),
    .wbm_dat_i (bus.wbm_dat_i),
    .wbm_we_o  (bus.wbm_we_o),
    .wbm_sel_o (bus.wbm_sel_o),
    .wbm_dat_o (bus.wbm_dat_o),
    .wbm_adr_o (bus.wbm_adr_o),
    .timeout_o (bus.timeout_o),
    .unmapped_o(bus.unmapped_o),
    .err_port_o(bus.err_port_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] model_rd = '0;
  logic        model_timeout = 1'b0;
  logic        model_unmapped = 1'b0;
  logic [2:0]  model_err_port = '0;

  function automatic int model_port(input logic [31:0] a);
    for (int k = 0; k < NP; k++) begin
      if ((a & MASK) == ((32'h3000_0000 + 32'(k) * 32'h1000) & MASK)) return k;
    end
    return -1;
  endfunction

  // Downstream device models
  int          delay[NP];
  bit          never_ack[NP];
  bit          noise = 1'b0;
  logic [31:0] resp_data[NP];
  int          wait_cnt[NP];
  int          rec_cnt = 0;
  int          rec_port;
  logic        rec_we;
  logic [3:0]  rec_sel;
  logic [31:0] rec_dat;
  logic [SAW-1:0] rec_adr;

  initial begin
    bus.wbm_ack_i = '0;
    bus.wbm_dat_i = '0;
    for (int k = 0; k < NP; k++) begin
      delay[k] = 0; never_ack[k] = 1'b0; resp_data[k] = '0; wait_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
        bus.wbm_ack_i[k] = 1'b0;
        bus.wbm_dat_i[k*32 +: 32] = $urandom;
        if (bus.wbm_cyc_o[k]) begin
          if (!never_ack[k] && wait_cnt[k] == delay[k]) begin
            bus.wbm_ack_i[k] = 1'b1;
            bus.wbm_dat_i[k*32 +: 32] = resp_data[k];
            rec_port = k; rec_we = bus.wbm_we_o; rec_sel = bus.wbm_sel_o;
            rec_dat = bus.wbm_dat_o; rec_adr = bus.wbm_adr_o; rec_cnt++;
          end
          wait_cnt[k]++;
        end else begin
          wait_cnt[k] = 0;
          if (noise) bus.wbm_ack_i[k] = 1'b1;
        end
      end
    end
  end

  // Downstream cycle monitor
  int         cyc_cycles = 0;
  bit         cyc_bad = 1'b0;
  logic [3:0] exp_sel = '0;

  always @(negedge clk) begin
    if (rst_n && bus.wbm_cyc_o != '0) begin
      cyc_cycles++;
      if (bus.wbm_cyc_o !== exp_sel || bus.wbm_stb_o !== bus.wbm_cyc_o) cyc_bad = 1'b1;
    end
  end

  task automatic run_txn(input string name, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
    int p, n, exp_n, exp_cyc, rec_before;
    logic [31:0] rd, exp_rd, off;
    logic ack_after;
    p = model_port(adr);
    exp_rd = model_rd;
    exp_cyc = 0;
    off = '0;
    if (p < 0) begin
      exp_n = 1; exp_rd = ERR; model_unmapped = 1'b1;
    end else if (never_ack[p]) begin
      exp_n = T + 1; exp_cyc = T; exp_rd = ERR; model_timeout = 1'b1; model_err_port = 3'(p);
    end else begin
      exp_n = delay[p] + 2; exp_cyc = delay[p] + 1;
      if (!we) exp_rd = resp_data[p];
      off = adr & ~MASK;
    end
    @(negedge clk);
    cyc_cycles = 0; cyc_bad = 1'b0; rec_before = rec_cnt;
    exp_sel = (p >= 0) ? 4'(1 << p) : 4'b0;
    bus.wbs_adr_i = adr; bus.wbs_we_i = we; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.wbs_ack_o !== 1'b1 && n < 100);
    rd = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    ack_after = bus.wbs_ack_o;
    model_rd = exp_rd;

    tests_run++;
    if (n !== exp_n) begin tests_failed++; $display("FAIL %s ack_latency got %0d expected %0d", name, n, exp_n); end
    tests_run++;
    if (rd !== exp_rd) begin tests_failed++; $display("FAIL %s rdata got %h expected %h", name, rd, exp_rd); end
    tests_run++;
    if (ack_after !== 1'b0) begin tests_failed++; $display("FAIL %s ack_width got %b expected 0", name, ack_after); end
    tests_run++;
    if (cyc_cycles !== exp_cyc) begin tests_failed++; $display("FAIL %s cyc_cycles got %0d expected %0d", name, cyc_cycles, exp_cyc); end
    tests_run++;
    if (cyc_bad !== 1'b0) begin tests_failed++; $display("FAIL %s cyc_select got bad expected one-hot port %0d", name, p); end
    tests_run++;
    if (bus.timeout_o !== model_timeout) begin tests_failed++; $display("FAIL %s timeout_o got %b expected %b", name, bus.timeout_o, model_timeout); end
    tests_run++;
    if (bus.unmapped_o !== model_unmapped) begin tests_failed++; $display("FAIL %s unmapped_o got %b expected %b", name, bus.unmapped_o, model_unmapped); end
    tests_run++;
    if (bus.err_port_o !== model_err_port) begin tests_failed++; $display("FAIL %s err_port_o got %0d expected %0d", name, bus.err_port_o, model_err_port); end
    if (p >= 0 && !never_ack[p]) begin
      tests_run++;
      if (rec_cnt !== rec_before + 1 || rec_port !== p) begin
        tests_failed++; $display("FAIL %s dn_port got %0d (acks %0d) expected %0d", name, rec_port, rec_cnt - rec_before, p);
      end
      tests_run++;
      if (rec_we !== we || rec_sel !== sel) begin
        tests_failed++; $display("FAIL %s dn_we_sel got %b/%b expected %b/%b", name, rec_we, rec_sel, we, sel);
      end
      tests_run++;
      if (rec_dat !== dat) begin tests_failed++; $display("FAIL %s dn_dat got %h expected %h", name, rec_dat, dat); end
      tests_run++;
      if (rec_adr !== off[SAW-1:0]) begin tests_failed++; $display("FAIL %s dn_adr got %h expected %h", name, rec_adr, off[SAW-1:0]); end
    end
  endtask

  task automatic test_reset();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.wbs_ack_o, bus.wbs_dat_o} !== '0) begin
      tests_failed++; $display("FAIL reset_wbs got %b/%h expected 0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    tests_run++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_adr_o} !== '0) begin
      tests_failed++; $display("FAIL reset_wbm got cyc %b adr %h expected 0", bus.wbm_cyc_o, bus.wbm_adr_o);
    end
    tests_run++;
    if ({bus.timeout_o, bus.unmapped_o, bus.err_port_o} !== '0) begin
      tests_failed++; $display("FAIL reset_flags got %b%b%0d expected 0", bus.timeout_o, bus.unmapped_o, bus.err_port_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_port2();
    delay[2] = 2; resp_data[2] = 32'h1234_5678;
    run_txn("read_p2", 32'h3000_2010, 1'b0, 32'h0, 4'hF);
  endtask

  task automatic test_write_port0();
    delay[0] = 1; resp_data[0] = 32'h0BAD_0BAD;
    run_txn("write_p0", 32'h3000_0FFC, 1'b1, 32'hA5A5_A5A5, 4'b0011);
  endtask

  task automatic test_unmapped();
    run_txn("unmapped", 32'h4000_0000, 1'b0, 32'h0, 4'hF);
    run_txn("unmapped_edge", 32'h3000_4000, 1'b1, 32'h1111_2222, 4'hF);
  endtask

  task automatic test_timeout();
    never_ack[3] = 1'b1;
    run_txn("timeout_p3", 32'h3000_3008, 1'b0, 32'h0, 4'hF);
    never_ack[3] = 1'b0;
    delay[1] = 0; resp_data[1] = 32'hCAFE_0001;
    run_txn("after_timeout", 32'h3000_1004, 1'b0, 32'h0, 4'hF);
  endtask

  task automatic test_abort();
    int acks;
    never_ack[1] = 1'b1;
    @(negedge clk);
    cyc_cycles = 0; cyc_bad = 1'b0; exp_sel = 4'b0010;
    bus.wbs_adr_i = 32'h3000_1040; bus.wbs_we_i = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.wbm_cyc_o !== 4'b0000) begin tests_failed++; $display("FAIL abort_cyc_drop got %b expected 0000", bus.wbm_cyc_o); end
    tests_run++;
    if (cyc_cycles !== 2 || cyc_bad) begin tests_failed++; $display("FAIL abort_cyc_cycles got %0d expected 2", cyc_cycles); end
    acks = int'(bus.wbs_ack_o);
    repeat (4) begin @(negedge clk); acks += int'(bus.wbs_ack_o); end
    tests_run++;
    if (acks !== 0) begin tests_failed++; $display("FAIL abort_no_ack got %0d expected 0", acks); end
    never_ack[1] = 1'b0; delay[1] = 1; resp_data[1] = 32'h5151_1515;
    run_txn("after_abort", 32'h3000_1100, 1'b0, 32'h0, 4'hF);
  endtask

  task automatic test_ignore_other_acks();
    noise = 1'b1; delay[1] = 4; resp_data[1] = $urandom;
    run_txn("noise_p1", 32'h3000_1234, 1'b0, 32'h0, 4'hF);
    noise = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NP; k++) begin
      delay[k] = 0; resp_data[k] = 32'h7700_0000 | 32'(k);
      run_txn("b2b", 32'h3000_0000 + 32'(k) * 32'h1000 + 32'h20, 1'b0, 32'h0, 4'hF);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NP; k++) begin
        delay[k] = $urandom_range(0, 5); resp_data[k] = $urandom;
      end
      case ($urandom_range(0, 5))
        0:       a = $urandom;
        1:       a = 32'h3000_4000 + $urandom_range(0, 32'h0FFF);
        default: a = 32'h3000_0000 + $urandom_range(0, 32'h3FFF);
      endcase
      run_txn("random", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_mid_req();
    tests_run++;
    if (bus.timeout_o !== model_timeout || bus.unmapped_o !== model_unmapped) begin
      tests_failed++; $display("FAIL flags_before_reset got %b%b expected %b%b", bus.timeout_o, bus.unmapped_o, model_timeout, model_unmapped);
    end
    never_ack[3] = 1'b1;
    @(negedge clk);
    cyc_bad = 1'b0; exp_sel = 4'b1000;
    bus.wbs_adr_i = 32'h3000_3000; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = 32'h6666_7777;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.wbm_cyc_o !== 4'b1000) begin tests_failed++; $display("FAIL mid_req_cyc got %b expected 1000", bus.wbm_cyc_o); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.wbs_ack_o, bus.wbs_dat_o} !== '0) begin
      tests_failed++; $display("FAIL async_reset_wbs got %b/%h expected 0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    tests_run++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_adr_o} !== '0) begin
      tests_failed++; $display("FAIL async_reset_wbm got cyc %b dat %h expected 0", bus.wbm_cyc_o, bus.wbm_dat_o);
    end
    tests_run++;
    if ({bus.timeout_o, bus.unmapped_o, bus.err_port_o} !== '0) begin
      tests_failed++; $display("FAIL async_reset_flags got %b%b%0d expected 0", bus.timeout_o, bus.unmapped_o, bus.err_port_o);
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    never_ack[3] = 1'b0;
    model_rd = '0; model_timeout = 1'b0; model_unmapped = 1'b0; model_err_port = '0;
    delay[0] = 2; resp_data[0] = 32'h0F0F_1234;
    run_txn("after_reset", 32'h3000_0124, 1'b0, 32'h0, 4'hF);
  endtask

  initial begin
    test_reset();
    test_read_port2();
    test_write_port0();
    test_unmapped();
    test_timeout();
    test_abort();
    test_ignore_other_acks();
    test_back_to_back();
    test_random();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
